// File: rtl/aud_pkg.sv
// aud_pkg: shared types and constants for the audio playback sample engine.
//   aud_mode_e  : playback mode (fast/normal, zero-order hold, linear interp)
//   aud_state_e : sample engine FSM state
//   decode_mode : maps the raw 2-bit mode input onto aud_mode_e
// Optional feature macro: AUD_DSP_LINEAR_EN (linear interpolation mode).
package aud_pkg;

  localparam int AUD_DATA_W  = 16;
  localparam int AUD_DIV_CYC = 20;
  // Interpolation product width; the divider retires one bit per cycle,
  // so this also sets the divide latency.
  localparam int AUD_PROD_W  = AUD_DIV_CYC;

  typedef enum logic [1:0] {
    MODE_FAST   = 2'd0,
    MODE_HOLD   = 2'd1,
    MODE_LINEAR = 2'd2
  } aud_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_FETCH_A = 3'd2,
    ST_FETCH_B = 3'd3,
    ST_DIV     = 3'd4,
    ST_OUT     = 3'd5,
    ST_PAUSED  = 3'd6
  } aud_state_e;

  // Mode 3 plays as fast/normal. Without the linear build, mode 2 is a hold.
  function automatic aud_mode_e decode_mode(input logic [1:0] m);
    aud_mode_e r;
    case (m)
      2'd1:    r = MODE_HOLD;
`ifdef AUD_DSP_LINEAR_EN
      2'd2:    r = MODE_LINEAR;
`else
      2'd2:    r = MODE_HOLD;
`endif
      default: r = MODE_FAST;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aud_dsp_if.sv
// aud_dsp_if: SRAM read bus and DAC serializer side of the sample engine.
//   o_sram_addr : word address to the SRAM
//   i_sram_data : SRAM read data, valid one cycle after the address
//   i_daclrck   : frame (left/right) clock, synchronous to the bit clock
//   o_dac_data  : signed sample to the serializer
//   o_en        : serializer enable
//   o_done      : one-cycle end-of-data pulse
// master = sample engine, slave = SRAM/serializer side.
interface aud_dsp_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic        [ADDR_W-1:0] o_sram_addr;
  logic        [DATA_W-1:0] i_sram_data;
  logic                     i_daclrck;
  logic signed [DATA_W-1:0] o_dac_data;
  logic                     o_en;
  logic                     o_done;

  modport master (
    output o_sram_addr, o_dac_data, o_en, o_done,
    input  i_sram_data, i_daclrck
  );

  modport slave (
    input  o_sram_addr, o_dac_data, o_en, o_done,
    output i_sram_data, i_daclrck
  );
endinterface

// File: rtl/aud_div.sv
// aud_div: sequential restoring divider, 20-bit signed dividend by 4-bit
// unsigned divisor, quotient truncated toward zero.
//   i_start    : load operands and begin (ignored while i_clr is high)
//   i_clr      : abandon any divide in progress
//   o_busy     : divide in progress
//   o_done     : high in the final iteration cycle; o_quotient valid then
//   o_quotient : low AUD_DATA_W bits of the signed quotient
// Latency is fixed at AUD_DIV_CYC cycles after the start cycle.
module aud_div
  import aud_pkg::*;
(
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         i_clr,
  input  logic signed [AUD_PROD_W-1:0] i_dividend,
  input  logic        [3:0]            i_divisor,
  output logic                         o_busy,
  output logic                         o_done,
  output logic signed [AUD_DATA_W-1:0] o_quotient
);

  localparam int CNT_W = $clog2(AUD_DIV_CYC + 1);

  logic [AUD_PROD_W-1:0] quo_q, quo_d;
  logic [3:0]            rem_q, rem_d;
  logic [3:0]            dvs_q, dvs_d;
  logic                  neg_q, neg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [4:0]            trial;
  logic                  fits;
  logic [AUD_PROD_W-1:0] quo_step;
  logic [AUD_PROD_W-1:0] dvd_u;
  logic [AUD_DATA_W-1:0] quo_low;

  // Divide on magnitudes, then reapply the sign: gives truncation toward zero.
  assign dvd_u    = i_dividend;
  assign trial    = {rem_q, quo_q[AUD_PROD_W-1]};
  assign fits     = (trial >= {1'b0, dvs_q});
  assign quo_step = {quo_q[AUD_PROD_W-2:0], fits};
  assign quo_low  = quo_step[AUD_DATA_W-1:0];

  assign o_busy     = (cnt_q != '0);
  // The last iteration is taken combinationally so the result is usable in
  // the same cycle it completes.
  assign o_done     = (cnt_q == CNT_W'(1));
  assign o_quotient = neg_q ? $signed(~quo_low + 1'b1) : $signed(quo_low);

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    neg_d = neg_q;
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_start) begin
      quo_d = i_dividend[AUD_PROD_W-1] ? (~dvd_u + 1'b1) : dvd_u;
      rem_d = '0;
      dvs_d = i_divisor;
      neg_d = i_dividend[AUD_PROD_W-1];
      cnt_d = CNT_W'(AUD_DIV_CYC);
    end else if (cnt_q != '0) begin
      quo_d = quo_step;
      // The true remainder is below the divisor, so 4-bit wrap is exact.
      rem_d = fits ? (trial[3:0] - dvs_q) : trial[3:0];
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      neg_q <= neg_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/aud_dsp.sv
// aud_dsp: playback sample engine ahead of the I2S DAC serializer.
// Reads 16-bit samples from SRAM, applies speed change (fast skip, slow hold,
// slow linear interpolation) and presents one sample per frame.
//   i_clk, i_rst_n   : bit clock, async active-low reset
//   i_start/pause/stop : one-cycle control pulses (stop > pause > start)
//   i_mode, i_speed, i_end_addr : latched on every accepted start/resume
//   bus (aud_dsp_if.master) : SRAM address/data, frame clock, DAC outputs
// Optional feature macro: AUD_DSP_LINEAR_EN compiles in FETCH_B, DIV and
// aud_div; without it mode 2 plays exactly as mode 1.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | stopped; after reset, stop or end of data
// WAIT     | running, waiting for a frame rise (end check happens here)
// FETCH_A  | address s[i] on the SRAM
// FETCH_B  | capture s[i], address s[i+1] (linear only)
// DIV      | interpolation divide; publishes when it completes (linear)
// OUT      | publish s[i] (modes 0/1)
// PAUSED   | position frozen, outputs quiet
module aud_dsp
  import aud_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = AUD_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  input  logic [2:0]        i_speed,
  input  logic [ADDR_W-1:0] i_end_addr,
  aud_dsp_if.master         bus
);

  aud_state_e               state_q, state_d;
  aud_mode_e                mode_q, mode_d;
  logic        [2:0]        nm1_q, nm1_d;
  logic        [ADDR_W-1:0] end_q, end_d;
  // One spare bit so i + N past the end never wraps.
  logic        [ADDR_W:0]   pos_q, pos_d;
  logic        [2:0]        ph_q, ph_d;
  logic                     lrck_q;
  logic        [ADDR_W-1:0] addr_q, addr_d;
  logic signed [DATA_W-1:0] dac_q, dac_d;
  logic                     en_q, en_d;
  logic                     done_q, done_d;

  logic                     rise;
  logic        [ADDR_W:0]   pos_adv;
  logic        [2:0]        ph_adv;

  assign rise = bus.i_daclrck && !lrck_q;

  assign bus.o_sram_addr = addr_q;
  assign bus.o_dac_data  = dac_q;
  assign bus.o_en        = en_q;
  assign bus.o_done      = done_q;

  // Position after a published sample.
  always_comb begin
    pos_adv = pos_q;
    ph_adv  = ph_q;
    if (mode_q == MODE_FAST) begin
      pos_adv = pos_q + (ADDR_W+1)'(nm1_q) + (ADDR_W+1)'(1);
    end else if (ph_q >= nm1_q) begin
      // >= rather than == in case a resume lowered the speed under k.
      pos_adv = pos_q + (ADDR_W+1)'(1);
      ph_adv  = '0;
    end else begin
      ph_adv = ph_q + 3'd1;
    end
  end

`ifdef AUD_DSP_LINEAR_EN
  logic signed [DATA_W-1:0]     sa_q, sa_d;
  logic                         div_start, div_clr, div_busy, div_done;
  logic signed [AUD_PROD_W-1:0] diff_w, prod_w;
  logic signed [DATA_W-1:0]     div_q;
  logic        [3:0]            n_w;
  logic        [ADDR_W-1:0]     addr_b;

  // s[i+1] arrives straight off the bus in the first DIV cycle.
  assign diff_w = {{(AUD_PROD_W-DATA_W){bus.i_sram_data[DATA_W-1]}}, bus.i_sram_data}
                - {{(AUD_PROD_W-DATA_W){sa_q[DATA_W-1]}}, sa_q};
  assign prod_w = diff_w * $signed({{(AUD_PROD_W-3){1'b0}}, ph_q});
  assign n_w    = {1'b0, nm1_q} + 4'd1;
  // At the last sample the successor is the sample itself.
  assign addr_b = (pos_q[ADDR_W-1:0] == end_q) ? pos_q[ADDR_W-1:0]
                                               : pos_q[ADDR_W-1:0] + ADDR_W'(1);

  aud_div u_div (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (div_start),
    .i_clr      (div_clr),
    .i_dividend (prod_w),
    .i_divisor  (n_w),
    .o_busy     (div_busy),
    .o_done     (div_done),
    .o_quotient (div_q)
  );
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    nm1_d   = nm1_q;
    end_d   = end_q;
    pos_d   = pos_q;
    ph_d    = ph_q;
    addr_d  = addr_q;
    dac_d   = dac_q;
    en_d    = en_q;
    done_d  = 1'b0;
`ifdef AUD_DSP_LINEAR_EN
    sa_d      = sa_q;
    div_start = 1'b0;
    div_clr   = 1'b0;
`endif
    if (i_stop) begin
      state_d = ST_IDLE;
      pos_d   = '0;
      ph_d    = '0;
      addr_d  = '0;
      dac_d   = '0;
      en_d    = 1'b0;
`ifdef AUD_DSP_LINEAR_EN
      div_clr = 1'b1;
`endif
    end else if (i_pause && state_q != ST_IDLE) begin
      state_d = ST_PAUSED;
      dac_d   = '0;
      en_d    = 1'b0;
`ifdef AUD_DSP_LINEAR_EN
      div_clr = 1'b1;
`endif
    end else if (i_start && (state_q == ST_IDLE || state_q == ST_PAUSED)) begin
      state_d = ST_WAIT;
      mode_d  = decode_mode(i_mode);
      nm1_d   = i_speed;
      end_d   = i_end_addr;
      if (state_q == ST_IDLE) begin
        pos_d = '0;
        ph_d  = '0;
      end
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (rise) begin
            // End is taken at the frame after the last sample, so that
            // sample keeps its full frame on the output.
            if (pos_q > {1'b0, end_q}) begin
              state_d = ST_IDLE;
              pos_d   = '0;
              ph_d    = '0;
              dac_d   = '0;
              en_d    = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = ST_FETCH_A;
              addr_d  = pos_q[ADDR_W-1:0];
            end
          end
        end
        ST_FETCH_A: begin
          state_d = ST_OUT;
`ifdef AUD_DSP_LINEAR_EN
          if (mode_q == MODE_LINEAR) begin
            state_d = ST_FETCH_B;
            addr_d  = addr_b;
          end
`endif
        end
        ST_OUT: begin
          dac_d   = bus.i_sram_data;
          en_d    = 1'b1;
          pos_d   = pos_adv;
          ph_d    = ph_adv;
          state_d = ST_WAIT;
        end
`ifdef AUD_DSP_LINEAR_EN
        ST_FETCH_B: begin
          sa_d    = bus.i_sram_data;
          state_d = ST_DIV;
        end
        ST_DIV: begin
          if (!div_busy) begin
            div_start = 1'b1;
          end else if (div_done) begin
            dac_d   = sa_q + div_q;
            en_d    = 1'b1;
            pos_d   = pos_adv;
            ph_d    = ph_adv;
            state_d = ST_WAIT;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_FAST;
      nm1_q   <= '0;
      end_q   <= '0;
      pos_q   <= '0;
      ph_q    <= '0;
      lrck_q  <= 1'b0;
      addr_q  <= '0;
      dac_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      nm1_q   <= nm1_d;
      end_q   <= end_d;
      pos_q   <= pos_d;
      ph_q    <= ph_d;
      lrck_q  <= bus.i_daclrck;
      addr_q  <= addr_d;
      dac_q   <= dac_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

`ifdef AUD_DSP_LINEAR_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sa_q <= '0;
    else          sa_q <= sa_d;
  end
`endif

endmodule

// File: tb/tb_aud_dsp.sv
// tb_aud_dsp: directed bench for aud_dsp with a registered SRAM model and
// a hand-driven frame clock; expected samples are hand-computed.
module tb_aud_dsp;
  import aud_pkg::*;

`ifdef AUD_DSP_LINEAR_EN
  localparam int LIN_LAT = 24;
  localparam int EXP_LIN [8] = '{0, -1, -3, -5, -7, -7, -7, -7};
  localparam int EXP_STOP2 = 50;
`else
  localparam int LIN_LAT = 3;
  localparam int EXP_LIN [8] = '{0, 0, 0, 0, -7, -7, -7, -7};
  localparam int EXP_STOP2 = 40;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [2:0]  speed = 3'd0;
  logic [19:0] end_addr = 20'd0;
  logic        lrck = 1'b0;
  logic [15:0] mem [16];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  aud_dsp_if #(.ADDR_W(20), .DATA_W(16)) bus ();

  assign bus.i_daclrck = lrck;
  always @(posedge clk) bus.i_sram_data <= mem[bus.o_sram_addr[3:0]];

  aud_dsp #(.ADDR_W(20), .DATA_W(16)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_pause    (pause),
    .i_stop     (stop),
    .i_mode     (mode),
    .i_speed    (speed),
    .i_end_addr (end_addr),
    .bus        (bus)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic st, input logic pa, input logic sp);
    @(negedge clk);
    start = st; pause = pa; stop = sp;
    @(negedge clk);
    start = 1'b0; pause = 1'b0; stop = 1'b0;
  endtask

  // One frame: rise, check address at t+1, old data at t+lat-1, new at t+lat.
  task automatic frame(input int lat, input int exp_addr, input int exp_old,
                       input int exp_new, input string tag);
    @(negedge clk);
    lrck = 1'b1;
    @(negedge clk);
    chk({tag, "_addr"}, bus.o_sram_addr, exp_addr);
    repeat (lat - 2) @(negedge clk);
    chk({tag, "_old"}, bus.o_dac_data, exp_old);
    @(negedge clk);
    chk({tag, "_new"}, bus.o_dac_data, exp_new);
    chk({tag, "_en"}, bus.o_en, 1);
    repeat (30 - lat) @(negedge clk);
    lrck = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic end_frame(input string tag);
    @(negedge clk);
    lrck = 1'b1;
    @(negedge clk);
    chk({tag, "_done"}, bus.o_done, 1);
    chk({tag, "_en"}, bus.o_en, 0);
    chk({tag, "_dac"}, bus.o_dac_data, 0);
    chk({tag, "_state"}, dut.state_q, ST_IDLE);
    @(negedge clk);
    chk({tag, "_done_off"}, bus.o_done, 0);
    repeat (28) @(negedge clk);
    lrck = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    logic seen;
    for (int a = 0; a < 16; a++) mem[a] = 16'(a * 10 + 10);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_addr", bus.o_sram_addr, 0);
    chk("rst_dac", bus.o_dac_data, 0);
    chk("rst_en", bus.o_en, 0);
    chk("rst_done", bus.o_done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset mid-play, mode 0, N = 1
    mode = 2'd0; speed = 3'd0; end_addr = 20'd15;
    pulse(1, 0, 0);
    frame(3, 0, 0, 10, "play");
    @(negedge clk);
    lrck = 1'b1;
    @(negedge clk);
    chk("play2_addr", bus.o_sram_addr, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr", bus.o_sram_addr, 0);
    chk("arst_dac", bus.o_dac_data, 0);
    chk("arst_en", bus.o_en, 0);
    chk("arst_done", bus.o_done, 0);
    chk("arst_state", dut.state_q, ST_IDLE);
    @(negedge clk);
    lrck = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= bus.o_done;
    end
    chk("arst_no_done", seen, 0);

    // Mode 0, N = 2, end = 5; a start while running is ignored
    mode = 2'd0; speed = 3'd1; end_addr = 20'd5;
    pulse(1, 0, 0);
    frame(3, 0, 0, 10, "fast0");
    mode = 2'd1; speed = 3'd0;
    pulse(1, 0, 0);
    frame(3, 2, 10, 30, "fast1");
    frame(3, 4, 30, 50, "fast2");
    end_frame("fast_end");

    // Mode 1, N = 3
    mem[0] = 16'd100; mem[1] = 16'hFF9C;
    mode = 2'd1; speed = 3'd2; end_addr = 20'd1;
    pulse(1, 0, 0);
    frame(3, 0, 0, 100, "hold0");
    frame(3, 0, 100, 100, "hold1");
    frame(3, 0, 100, 100, "hold2");
    frame(3, 1, 100, -100, "hold3");
    frame(3, 1, -100, -100, "hold4");
    frame(3, 1, -100, -100, "hold5");
    end_frame("hold_end");

    // Mode 2, N = 4, s = 0, -7
    mem[0] = 16'd0; mem[1] = 16'hFFF9;
    mode = 2'd2; speed = 3'd3; end_addr = 20'd1;
    pulse(1, 0, 0);
    for (int f = 0; f < 8; f++)
      frame(LIN_LAT, (f < 4) ? 0 : 1, (f == 0) ? 0 : EXP_LIN[f-1], EXP_LIN[f], "lin");
    end_frame("lin_end");

    // Pause after the 2nd output of mode 1, N = 2, then resume
    mem[0] = 16'd11; mem[1] = 16'd22; mem[2] = 16'd33;
    mode = 2'd1; speed = 3'd1; end_addr = 20'd2;
    pulse(1, 0, 0);
    frame(3, 0, 0, 11, "pz0");
    frame(3, 0, 11, 11, "pz1");
    pulse(0, 1, 0);
    chk("pz_en", bus.o_en, 0);
    chk("pz_dac", bus.o_dac_data, 0);
    chk("pz_addr", bus.o_sram_addr, 0);
    @(negedge clk);
    lrck = 1'b1;
    repeat (5) @(negedge clk);
    chk("pz_frame_dac", bus.o_dac_data, 0);
    chk("pz_frame_en", bus.o_en, 0);
    repeat (25) @(negedge clk);
    lrck = 1'b0;
    repeat (30) @(negedge clk);
    pulse(1, 0, 0);
    frame(3, 1, 0, 22, "pz2");
    frame(3, 1, 22, 22, "pz3");
    frame(3, 2, 22, 33, "pz4");
    frame(3, 2, 33, 33, "pz5");
    end_frame("pz_end");
    pulse(0, 1, 0);
    chk("idle_pause_ignored", dut.state_q, ST_IDLE);

    // Stop and pause together mid-divide; stop wins, replay from s[0]
    mem[0] = 16'd40; mem[1] = 16'd80;
    mode = 2'd2; speed = 3'd3; end_addr = 20'd1;
    pulse(1, 0, 0);
    frame(LIN_LAT, 0, 0, 40, "sp0");
    @(negedge clk);
    lrck = 1'b1;
    repeat (10) @(negedge clk);
    pulse(0, 1, 1);
    chk("sp_state", dut.state_q, ST_IDLE);
    chk("sp_en", bus.o_en, 0);
    chk("sp_dac", bus.o_dac_data, 0);
    chk("sp_addr", bus.o_sram_addr, 0);
    repeat (30) @(negedge clk);
    chk("sp_discard", bus.o_dac_data, 0);
    chk("sp_still_idle", dut.state_q, ST_IDLE);
    lrck = 1'b0;
    repeat (30) @(negedge clk);
    pulse(1, 0, 0);
    frame(LIN_LAT, 0, 0, 40, "sp_replay0");
    frame(LIN_LAT, 0, 40, EXP_STOP2, "sp_replay1");
    pulse(0, 0, 1);
    chk("sp_final_en", bus.o_en, 0);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
